// File: rtl/wishbone_crossbar.sv
// wishbone_crossbar: N-master x M-slave Wishbone classic crossbar.
// Each slave has a registered round-robin arbiter that locks the grant for a whole CYC.
// Unmapped requests get a one-cycle registered ERR.
// Optional slave watchdog: define WB_XBAR_TIMEOUT_EN (uses TIMEOUT_CYCLES).
module wishbone_crossbar #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned N_SLAVES  = 3,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'h80000000, 32'h10000000, 32'h00000000},
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = {32'h80000000, 32'hF0000000, 32'hF0000000},
    parameter logic [N_SLAVES-1:0] STRIP_BASE = 3'b100,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned SEL_W = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_cycle,
    input  logic [N_MASTERS-1:0]          m_strobe,
    input  logic [N_MASTERS-1:0]          m_write_enable,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_address,
    input  logic [N_MASTERS*SEL_W-1:0]    m_select,
    input  logic [N_MASTERS*DATA_W-1:0]   m_data_in,
    output logic [N_MASTERS*DATA_W-1:0]   m_data_out,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic [N_MASTERS-1:0]          m_err,
    output logic [N_SLAVES-1:0]           s_cycle,
    output logic [N_SLAVES-1:0]           s_strobe,
    output logic [N_SLAVES-1:0]           s_write_enable,
    output logic [N_SLAVES*ADDR_W-1:0]    s_address,
    output logic [N_SLAVES*SEL_W-1:0]     s_select,
    output logic [N_SLAVES*DATA_W-1:0]    s_data_in,
    input  logic [N_SLAVES*DATA_W-1:0]    s_data_out,
    input  logic [N_SLAVES-1:0]           s_ack
);

    localparam int unsigned MIDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int unsigned SIDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e              state_q [N_SLAVES];
    state_e              state_d [N_SLAVES];
    logic [MIDX_W-1:0]   grant_q [N_SLAVES];
    logic [MIDX_W-1:0]   grant_d [N_SLAVES];
    logic [MIDX_W-1:0]   rr_q    [N_SLAVES];
    logic [MIDX_W-1:0]   rr_d    [N_SLAVES];
    logic [N_MASTERS-1:0] err_q, err_d;

    logic [N_MASTERS-1:0] req, hit_any, held;
    logic [SIDX_W-1:0]    hit_idx [N_MASTERS];
    logic [N_SLAVES-1:0]  tmo;

    // Address decode per master (lowest slave wins) and which masters already own a slave
    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            req[i]     = m_cycle[i] & m_strobe[i];
            hit_any[i] = 1'b0;
            hit_idx[i] = '0;
            held[i]    = 1'b0;
            for (int j = N_SLAVES - 1; j >= 0; j--) begin
                if ((m_address[i*ADDR_W +: ADDR_W] & SLAVE_MASK[j*ADDR_W +: ADDR_W])
                        == SLAVE_BASE[j*ADDR_W +: ADDR_W]) begin
                    hit_any[i] = 1'b1;
                    hit_idx[i] = SIDX_W'(j);
                end
                if ((state_q[j] == S_BUSY) && (int'(grant_q[j]) == i)) begin
                    held[i] = 1'b1;
                end
            end
        end
    end

    // Arbiter next state: round-robin grant in IDLE, hold until the owner drops CYC
    always_comb begin
        int   m;
        logic found;
        m     = 0;
        found = 1'b0;
        err_d = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            err_d[i] = req[i] & ~hit_any[i] & ~held[i] & ~err_q[i];
        end
        for (int j = 0; j < N_SLAVES; j++) begin
            state_d[j] = state_q[j];
            grant_d[j] = grant_q[j];
            rr_d[j]    = rr_q[j];
            found      = 1'b0;
            case (state_q[j])
                S_IDLE: begin
                    for (int k = 0; k < N_MASTERS; k++) begin
                        m = (int'(rr_q[j]) + k) % N_MASTERS;
                        if (!found && req[m] && hit_any[m] && (int'(hit_idx[m]) == j) && !held[m]) begin
                            found      = 1'b1;
                            grant_d[j] = MIDX_W'(m);
                            rr_d[j]    = MIDX_W'((m + 1) % N_MASTERS);
                            state_d[j] = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (!m_cycle[int'(grant_q[j])] || tmo[j]) begin
                        state_d[j] = S_IDLE;
                    end
                end
                default: state_d[j] = S_IDLE;
            endcase
        end
    end

`ifdef WB_XBAR_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q [N_SLAVES];
    logic [CNT_W-1:0] cnt_d [N_SLAVES];

    // Watchdog: count strobed cycles without ACK while a slave is owned
    always_comb begin
        for (int j = 0; j < N_SLAVES; j++) begin
            tmo[j]   = (state_q[j] == S_BUSY) && (cnt_q[j] == CNT_W'(TIMEOUT_CYCLES));
            cnt_d[j] = '0;
            if ((state_q[j] == S_BUSY) && !tmo[j] && !s_ack[j]
                    && m_cycle[int'(grant_q[j])] && m_strobe[int'(grant_q[j])]) begin
                cnt_d[j] = cnt_q[j] + CNT_W'(1);
            end
        end
    end

    // Watchdog counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < N_SLAVES; j++) cnt_q[j] <= '0;
        end else begin
            for (int j = 0; j < N_SLAVES; j++) cnt_q[j] <= cnt_d[j];
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign tmo = '0;
`endif

    // Arbiter state, grant, round-robin pointer and unmapped-error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
            for (int j = 0; j < N_SLAVES; j++) begin
                state_q[j] <= S_IDLE;
                grant_q[j] <= '0;
                rr_q[j]    <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int j = 0; j < N_SLAVES; j++) begin
                state_q[j] <= state_d[j];
                grant_q[j] <= grant_d[j];
                rr_q[j]    <= rr_d[j];
            end
        end
    end

    // Datapath: owning master drives its slave; ACK/data return only to the owner
    always_comb begin
        int                g;
        logic [ADDR_W-1:0] addr;
        g              = 0;
        addr           = '0;
        s_cycle        = '0;
        s_strobe       = '0;
        s_write_enable = '0;
        s_address      = '0;
        s_select       = '0;
        s_data_in      = '0;
        m_ack          = '0;
        m_data_out     = '0;
        m_err          = err_q;
        for (int j = 0; j < N_SLAVES; j++) begin
            if (state_q[j] == S_BUSY) begin
                g    = int'(grant_q[j]);
                addr = m_address[g*ADDR_W +: ADDR_W];
                // Only strip when the address still lies in this slave's window
                if (STRIP_BASE[j] && ((addr & SLAVE_MASK[j*ADDR_W +: ADDR_W])
                        == SLAVE_BASE[j*ADDR_W +: ADDR_W])) begin
                    addr = addr & ~SLAVE_MASK[j*ADDR_W +: ADDR_W];
                end
                s_cycle[j]                      = m_cycle[g] & ~tmo[j];
                s_strobe[j]                     = m_strobe[g] & ~tmo[j];
                s_write_enable[j]               = m_write_enable[g];
                s_address[j*ADDR_W +: ADDR_W]   = addr;
                s_select[j*SEL_W +: SEL_W]      = m_select[g*SEL_W +: SEL_W];
                s_data_in[j*DATA_W +: DATA_W]   = m_data_in[g*DATA_W +: DATA_W];
                m_ack[g]                        = s_ack[j] & ~tmo[j];
                m_data_out[g*DATA_W +: DATA_W]  = s_data_out[j*DATA_W +: DATA_W];
                m_err[g]                        = m_err[g] | tmo[j];
            end
        end
    end

endmodule

// File: tb/tb_wishbone_crossbar.sv
// tb_wishbone_crossbar: two master BFMs, three memory slaves, scoreboard per master.
module tb_wishbone_crossbar;

    logic        clk;
    logic        rst;
    logic [1:0]  m_cycle, m_strobe, m_write_enable, m_ack, m_err;
    logic [63:0] m_address, m_data_in, m_data_out;
    logic [7:0]  m_select;
    logic [2:0]  s_cycle, s_strobe, s_write_enable, s_ack;
    logic [95:0] s_address, s_data_in, s_data_out;
    logic [11:0] s_select;

    logic        mc [2];
    logic        ms [2];
    logic        mwe [2];
    logic [31:0] madr [2];
    logic [31:0] mdat [2];
    logic [3:0]  msel [2];
    logic        sack [3];
    logic [31:0] sdat [3];
    logic        stall [3];
    int          dly [3];

    logic [31:0] smem [3][16];
    logic [31:0] mmem [3][16];
    logic [31:0] rbase [4];

    typedef struct packed {
        logic        err;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   ack_log[$];
    int   checks;
    int   errors;

    wishbone_crossbar dut (
        .clk(clk), .rst(rst),
        .m_cycle(m_cycle), .m_strobe(m_strobe), .m_write_enable(m_write_enable),
        .m_address(m_address), .m_select(m_select), .m_data_in(m_data_in),
        .m_data_out(m_data_out), .m_ack(m_ack), .m_err(m_err),
        .s_cycle(s_cycle), .s_strobe(s_strobe), .s_write_enable(s_write_enable),
        .s_address(s_address), .s_select(s_select), .s_data_in(s_data_in),
        .s_data_out(s_data_out), .s_ack(s_ack)
    );

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            m_cycle[i]            = mc[i];
            m_strobe[i]           = ms[i];
            m_write_enable[i]     = mwe[i];
            m_address[i*32 +: 32] = madr[i];
            m_data_in[i*32 +: 32] = mdat[i];
            m_select[i*4 +: 4]    = msel[i];
        end
        for (int j = 0; j < 3; j++) begin
            s_ack[j]               = sack[j];
            s_data_out[j*32 +: 32] = sdat[j];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_s_cycle"},   32'(s_cycle), 32'h0);
        chk({tag, "_s_strobe"},  32'(s_strobe), 32'h0);
        chk({tag, "_s_we"},      32'(s_write_enable), 32'h0);
        chk({tag, "_s_address"}, 32'(|s_address), 32'h0);
        chk({tag, "_s_sel_dat"}, 32'(|{s_select, s_data_in}), 32'h0);
        chk({tag, "_m_ack_err"}, 32'({m_ack, m_err}), 32'h0);
        chk({tag, "_m_data"},    32'(|m_data_out), 32'h0);
    endtask

    // Monitor: every ACK/ERR seen by a master consumes one scoreboard entry
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (m_ack[i] || m_err[i]) begin
                    if (m_ack[i]) ack_log.push_back(i);
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp m%0d: ack=%b err=%b with nothing outstanding",
                                 i, m_ack[i], m_err[i]);
                    end else begin
                        if (i == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk($sformatf("resp_kind_m%0d {ack,err}", i),
                            32'({m_ack[i], m_err[i]}), 32'({~e.err, e.err}));
                        if (e.rd && !e.err) begin
                            chk($sformatf("rdata_m%0d", i), m_data_out[i*32 +: 32], e.data);
                        end
                    end
                end
            end
        end
    endtask

    // Memory slaves: ACK after random wait, read data tagged with the address seen
    task automatic slaves();
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  idx;
        forever begin
            @(posedge clk);
            #2;
            for (int j = 0; j < 3; j++) begin
                if (sack[j]) begin
                    sack[j] = 1'b0;
                end else if (s_cycle[j] && s_strobe[j] && !stall[j]) begin
                    if (dly[j] > 0) begin
                        dly[j]--;
                    end else begin
                        a   = s_address[j*32 +: 32];
                        idx = a[5:2];
                        if (s_write_enable[j]) begin
                            d = smem[j][idx];
                            for (int b = 0; b < 4; b++) begin
                                if (s_select[j*4 + b]) d[b*8 +: 8] = s_data_in[j*32 + b*8 +: 8];
                            end
                            smem[j][idx] = d;
                            sdat[j] = '0;
                        end else begin
                            sdat[j] = smem[j][idx] ^ a;
                        end
                        sack[j] = 1'b1;
                        dly[j]  = int'($urandom_range(0, 3));
                    end
                end
            end
        end
    endtask

    // Master BFM: predict the response, run one classic cycle, release CYC
    task automatic txn(input int i, input int r, input int k, input logic we,
                       input logic [3:0] sel, input logic [31:0] wd, input int gap);
        logic [31:0] a;
        exp_t        e;
        int          n;
        a      = rbase[r] + 32'(k * 4);
        e.err  = (r == 3);
        e.rd   = !we;
        e.data = '0;
        if (r != 3) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel[b]) mmem[r][k][b*8 +: 8] = wd[b*8 +: 8];
                end
            end else begin
                e.data = mmem[r][k] ^ ((r == 2) ? (a & ~32'h80000000) : a);
            end
        end
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk);
        #1;
        mc[i] = 1'b1; ms[i] = 1'b1; mwe[i] = we; madr[i] = a; msel[i] = sel; mdat[i] = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_ack[i] || m_err[i]) && n < 300);
        if (!(m_ack[i] || m_err[i])) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout m%0d addr=%h: no ack/err within 300 cycles", i, a);
        end
        @(posedge clk);
        #1;
        mc[i] = 1'b0; ms[i] = 1'b0; mwe[i] = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    initial begin : main
        int          n;
        int          nerr;
        logic        saw_cyc;
        logic [31:0] v;
        checks = 0;
        errors = 0;
        rbase[0] = 32'h00000000;
        rbase[1] = 32'h10000000;
        rbase[2] = 32'h80000000;
        rbase[3] = 32'h40000000;
        for (int i = 0; i < 2; i++) begin
            mc[i] = 1'b0; ms[i] = 1'b0; mwe[i] = 1'b0;
            madr[i] = '0; mdat[i] = '0; msel[i] = '0;
        end
        for (int j = 0; j < 3; j++) begin
            sack[j] = 1'b0; sdat[j] = '0; stall[j] = 1'b0; dly[j] = 0;
            for (int k = 0; k < 16; k++) begin
                v = $urandom;
                smem[j][k] = v;
                mmem[j][k] = v;
            end
        end
        smem[2][4] = 32'hDEADBEEF ^ 32'h00000010;
        mmem[2][4] = 32'hDEADBEEF ^ 32'h00000010;
        rst = 1'b1;

        fork
            monitor();
            slaves();
        join_none

        // Reset and idle
        repeat (2) @(negedge clk);
        chk_idle("in_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("after_reset");

        // Read through the stripping slave
        fork
            txn(0, 2, 4, 1'b0, 4'hF, 32'h0, 1);
            begin
                @(posedge clk); @(posedge clk); @(negedge clk);
                chk("strip_s_cycle", 32'(s_cycle), 32'h4);
                chk("strip_s_address", s_address[95:64], 32'h00000010);
                n = 0;
                while (!m_ack[0] && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk("strip_m_ack", 32'(m_ack[0]), 32'h1);
                chk("strip_m_data", m_data_out[31:0], 32'hDEADBEEF);
            end
        join
        repeat (3) @(negedge clk);

        // Different slaves proceed concurrently
        fork
            txn(0, 1, 0, 1'b1, 4'b0001, $urandom, 1);
            txn(1, 0, 1, 1'b0, 4'hF, 32'h0, 1);
            begin
                @(posedge clk); @(posedge clk); @(negedge clk);
                chk("conc_s_cycle", 32'(s_cycle[1:0]), 32'h3);
                chk("conc_s1_address", s_address[63:32], 32'h10000000);
                chk("conc_s1_sel_we", 32'({s_select[7:4], s_write_enable[1]}), 32'h3);
                chk("conc_s0_address", s_address[31:0], 32'h00000004);
            end
        join
        repeat (3) @(negedge clk);

        // Unmapped address: one ERR pulse, no slave cycle
        fork
            txn(0, 3, 0, 1'b0, 4'hF, 32'h0, 1);
            begin
                nerr = 0;
                saw_cyc = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    if (m_err[0]) nerr++;
                    saw_cyc = saw_cyc | (|s_cycle);
                end
                chk("unmapped_err_pulses", 32'(nerr), 32'h1);
                chk("unmapped_no_s_cycle", 32'(saw_cyc), 32'h0);
            end
        join
        repeat (3) @(negedge clk);

        // Contention on one slave alternates masters
        ack_log.delete();
        fork
            begin
                txn(0, 0, 2, 1'b0, 4'hF, 32'h0, 0);
                txn(0, 0, 3, 1'b0, 4'hF, 32'h0, 0);
            end
            begin
                txn(1, 0, 10, 1'b0, 4'hF, 32'h0, 0);
                txn(1, 0, 11, 1'b0, 4'hF, 32'h0, 0);
            end
        join
        repeat (3) @(negedge clk);
        chk("rr_ack_count", 32'(ack_log.size()), 32'h4);
        for (int t = 0; t < 4 && t < ack_log.size(); t++) begin
            chk($sformatf("rr_order[%0d]", t), 32'(ack_log[t]), 32'(t % 2));
        end

        // Randomized concurrent traffic from both masters
        fork
            for (int t = 0; t < 40; t++) begin
                txn(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(1, 15)), $urandom, int'($urandom_range(0, 2)));
            end
            for (int t = 0; t < 40; t++) begin
                txn(1, int'($urandom_range(0, 3)), int'($urandom_range(8, 15)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(1, 15)), $urandom, int'($urandom_range(0, 2)));
            end
        join
        repeat (4) @(negedge clk);

        // Asynchronous reset while a slave is owned and stalled
        stall[1] = 1'b1;
        @(posedge clk);
        #1;
        mc[0] = 1'b1; ms[0] = 1'b1; mwe[0] = 1'b0; madr[0] = 32'h10000020; msel[0] = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_cycle[1] && n < 10);
        chk("busy_before_reset", 32'(s_cycle[1]), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("reset_drops_s_cycle", 32'(s_cycle), 32'h0);
        mc[0] = 1'b0; ms[0] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        stall[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("after_mid_reset");

        repeat (5) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
